booth_adder_callee: RTL and testbench

- Responder (callee) end of the multiplier's adder interface: accepts a two-operand add request on Adder_valid and returns the sum with a one-cycle Adder_ack pulse.
- Implemented as a chunked ripple-carry adder: processes CHUNK bits per clock and keeps the carry in a register between chunks.
- Sits beside the booth multiplier and serves its A+M and A+(-M) requests.
- Also usable by any other initiator that obeys the same valid/ack rules.

---
 rtl/booth_adder_callee.sv | 92 +++++++++
 tb/tb_booth_adder_callee.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/booth_adder_callee.sv
// Callee side of the booth multiplier's adder handshake: a chunked ripple-carry
// adder that adds CHUNK bits per clock and returns the sum with a one-cycle ack.
module booth_adder_callee #(
  parameter int WIDTH = 25,
  parameter int CHUNK = 5
) (
  input  logic             CLK,
  input  logic             RSTK,
  input  logic [WIDTH-1:0] Adder_datain1,
  input  logic [WIDTH-1:0] Adder_datain2,
  input  logic             Adder_valid,
  output logic [WIDTH-1:0] Adder_dataout,
  output logic             Adder_carryout,
  output logic             Adder_ack
);

  // IDLE: wait for valid | COMPUTE: one chunk per clock | DONE: ack cycle | WAIT_LOW: wait for valid=0
  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE, WAIT_LOW} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, res_d;
  logic             cy_q;
  logic [IW-1:0]    idx_q;
  logic [CHUNK:0]   csum;
  logic             last_chunk;

  // Operands shift down one chunk per cycle so the low CHUNK bits are always the
  // active chunk; the partial result shifts in from the top and lands aligned.
  always_comb begin
    csum       = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, cy_q};
    res_d      = res_q >> CHUNK;
    res_d[WIDTH-1 -: CHUNK] = csum[CHUNK-1:0];
    last_chunk = (idx_q == IW'(NCH - 1));
  end

  always_ff @(posedge CLK or posedge RSTK) begin
    if (RSTK) begin
      state_q        <= IDLE;
      a_q            <= '0;
      b_q            <= '0;
      res_q          <= '0;
      cy_q           <= 1'b0;
      idx_q          <= '0;
      Adder_dataout  <= '0;
      Adder_carryout <= 1'b0;
      Adder_ack      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          Adder_ack <= 1'b0;
          if (Adder_valid) begin
            a_q     <= Adder_datain1;
            b_q     <= Adder_datain2;
            res_q   <= '0;
            cy_q    <= 1'b0;
            idx_q   <= '0;
            state_q <= COMPUTE;
          end
        end
        COMPUTE: begin
          a_q   <= a_q >> CHUNK;
          b_q   <= b_q >> CHUNK;
          res_q <= res_d;
          cy_q  <= csum[CHUNK];
          idx_q <= idx_q + IW'(1);
          if (last_chunk) begin
            Adder_dataout  <= res_d;
            Adder_carryout <= csum[CHUNK];
            Adder_ack      <= 1'b1;
            state_q        <= DONE;
          end
        end
        DONE: begin
          Adder_ack <= 1'b0;
          state_q   <= WAIT_LOW;
        end
        WAIT_LOW: begin
          Adder_ack <= 1'b0;
          if (!Adder_valid) state_q <= IDLE;
        end
        default: begin
          Adder_ack <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_adder_callee.sv
// Self-checking bench for booth_adder_callee: directed scenarios plus random adds
// compared against a plain (WIDTH+1)-bit arithmetic sum.
module tb_booth_adder_callee;

  localparam int WIDTH = 25;
  localparam int CHUNK = 5;
  localparam int NCH   = WIDTH / CHUNK;
  localparam int LAT   = NCH + 1;

  logic             CLK;
  logic             RSTK;
  logic [WIDTH-1:0] din1, din2;
  logic             valid;
  logic [WIDTH-1:0] dout;
  logic             cout;
  logic             ack;

  int n_checks = 0;
  int n_fail   = 0;

  booth_adder_callee #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .CLK           (CLK),
    .RSTK          (RSTK),
    .Adder_datain1 (din1),
    .Adder_datain2 (din2),
    .Adder_valid   (valid),
    .Adder_dataout (dout),
    .Adder_carryout(cout),
    .Adder_ack     (ack)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Stimulus driver only: issues a request, measures latency, counts dataout
  // changes before ack; optionally corrupts operands mid-compute and drops valid.
  task automatic run_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input int change_at, input bit drop,
                         output int lat, output bit to, output int glitch, output logic ack_after);
    logic [WIDTH-1:0] prev;
    prev   = dout;
    din1   = a;
    din2   = b;
    valid  = 1'b1;
    lat    = 0;
    to     = 1'b1;
    glitch = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge CLK); #1;
      if (ack === 1'b1) begin
        lat = n;
        to  = 1'b0;
        break;
      end
      if (dout !== prev) glitch++;
      if (n == change_at) begin
        din1 = 25'h1555555;
        din2 = 25'h1555555;
      end
    end
    ack_after = 1'b0;
    if (drop) begin
      valid = 1'b0;
      @(posedge CLK); #1;
      ack_after = ack;
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_reset();
    valid = 1'b0; din1 = '0; din2 = '0; RSTK = 1'b0;
    #2 RSTK = 1'b1;
    #1;
    n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got=%b exp=0", ack); end
    n_checks++; if (dout !== '0) begin n_fail++; $display("FAIL reset_dout got=%h exp=0", dout); end
    n_checks++; if (cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout got=%b exp=0", cout); end
    @(posedge CLK); #1;
    RSTK = 1'b0;
  endtask

  task automatic test_basic();
    int lat, gl; bit to; logic aa;
    run_add(25'h0000005, 25'h0000003, 0, 1'b1, lat, to, gl, aa);
    n_checks++; if (to || lat != LAT) begin n_fail++; $display("FAIL basic_latency got=%0d exp=%0d timeout=%0d", lat, LAT, to); end
    n_checks++; if (dout !== 25'h0000008) begin n_fail++; $display("FAIL basic_dout got=%h exp=0000008", dout); end
    n_checks++; if (cout !== 1'b0) begin n_fail++; $display("FAIL basic_cout got=%b exp=0", cout); end
    n_checks++; if (aa !== 1'b0) begin n_fail++; $display("FAIL basic_ack_pulse got=%b exp=0", aa); end
    n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL basic_ack_low got=%b exp=0", ack); end
  endtask

  task automatic test_carry();
    int lat, gl; bit to; logic aa;
    run_add(25'h1FFFFFF, 25'h0000001, 0, 1'b1, lat, to, gl, aa);
    n_checks++; if (to || dout !== 25'h0000000) begin n_fail++; $display("FAIL ripple_dout got=%h exp=0000000", dout); end
    n_checks++; if (cout !== 1'b1) begin n_fail++; $display("FAIL ripple_cout got=%b exp=1", cout); end
    run_add(25'h0FFFFFF, 25'h0FFFFFF, 0, 1'b1, lat, to, gl, aa);
    n_checks++; if (to || dout !== 25'h1FFFFFE) begin n_fail++; $display("FAIL half_dout got=%h exp=1FFFFFE", dout); end
    n_checks++; if (cout !== 1'b0) begin n_fail++; $display("FAIL half_cout got=%b exp=0", cout); end
  endtask

  task automatic test_operand_change();
    int lat, gl; bit to; logic aa;
    run_add(25'h0000003, 25'h1FFFFFB, 2, 1'b1, lat, to, gl, aa);
    n_checks++; if (to || lat != LAT) begin n_fail++; $display("FAIL sub_latency got=%0d exp=%0d", lat, LAT); end
    n_checks++; if (dout !== 25'h1FFFFFE) begin n_fail++; $display("FAIL sub_dout got=%h exp=1FFFFFE", dout); end
    n_checks++; if (cout !== 1'b0) begin n_fail++; $display("FAIL sub_cout got=%b exp=0", cout); end
  endtask

  task automatic test_valid_stuck();
    int lat, gl, extra; bit to; logic aa;
    run_add(25'h0000100, 25'h0000200, 0, 1'b0, lat, to, gl, aa);
    n_checks++; if (to || dout !== 25'h0000300) begin n_fail++; $display("FAIL stuck_first got=%h exp=0000300", dout); end
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge CLK); #1;
      if (ack !== 1'b0) extra++;
    end
    n_checks++; if (extra != 0) begin n_fail++; $display("FAIL stuck_no_reack got=%0d acks exp=0", extra); end
    valid = 1'b0;
    @(posedge CLK); #1;
    run_add(25'h0000010, 25'h0000020, 0, 1'b1, lat, to, gl, aa);
    n_checks++; if (to || lat != LAT) begin n_fail++; $display("FAIL stuck_relatency got=%0d exp=%0d", lat, LAT); end
    n_checks++; if (dout !== 25'h0000030) begin n_fail++; $display("FAIL stuck_dout got=%h exp=0000030", dout); end
  endtask

  task automatic test_reset_mid();
    int lat, gl, extra; bit to; logic aa;
    din1 = 25'h0000007; din2 = 25'h0000009; valid = 1'b1;
    for (int i = 0; i < 4; i++) begin @(posedge CLK); #1; end
    #3 RSTK = 1'b1; valid = 1'b0;
    #1;
    n_checks++; if (dout !== '0 || cout !== 1'b0 || ack !== 1'b0) begin n_fail++;
      $display("FAIL midreset_outputs got dout=%h cout=%b ack=%b exp 0/0/0", dout, cout, ack); end
    #1 RSTK = 1'b0;
    @(posedge CLK); #1;
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      if (ack !== 1'b0 || dout !== '0) extra++;
    end
    n_checks++; if (extra != 0) begin n_fail++; $display("FAIL midreset_no_ack got=%0d bad cycles exp=0", extra); end
    run_add(25'h0000001, 25'h0000001, 0, 1'b1, lat, to, gl, aa);
    n_checks++; if (to || lat != LAT || dout !== 25'h0000002) begin n_fail++;
      $display("FAIL midreset_after got lat=%0d dout=%h exp lat=%0d dout=0000002", lat, dout, LAT); end
  endtask

  task automatic test_random();
    int lat, gl; bit to; logic aa;
    logic [WIDTH-1:0] a, b;
    logic [WIDTH:0]   exp;
    for (int i = 0; i < 24; i++) begin
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      if (i % 6 == 0) b = ~a + WIDTH'(i % 3);
      exp = ref_add(a, b);
      run_add(a, b, (i % 4 == 1) ? 3 : 0, 1'b1, lat, to, gl, aa);
      n_checks++; if (to || lat != LAT) begin n_fail++; $display("FAIL rand_latency[%0d] got=%0d exp=%0d", i, lat, LAT); end
      n_checks++; if ({cout, dout} !== exp) begin n_fail++;
        $display("FAIL rand_sum[%0d] a=%h b=%h got=%b_%h exp=%b_%h", i, a, b, cout, dout, exp[WIDTH], exp[WIDTH-1:0]); end
      n_checks++; if (gl != 0) begin n_fail++; $display("FAIL rand_partial[%0d] got=%0d changes exp=0", i, gl); end
      n_checks++; if (aa !== 1'b0) begin n_fail++; $display("FAIL rand_ack_pulse[%0d] got=%b exp=0", i, aa); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_operand_change();
    test_valid_stuck();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
